// File: rtl/seg_pkg.sv
// Shared constants and types for the eight-digit seven-segment frame scanner.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-high.
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned SEG_W      = 7;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;
   localparam logic [SEG_W-1:0] SEG_P = 7'b1110011;

   localparam logic [NUM_DIGITS-1:0] BLANK_AN  = '1;
   localparam logic [SEG_W-1:0]      BLANK_SEG = '1;

   typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_frame_t;

   typedef struct packed {
      logic [NUM_DIGITS-1:0] en;
      seg_frame_t            seg;
      logic [NUM_DIGITS-1:0] blink;
   } frame_t;

   typedef enum logic {
      PEND_EMPTY,
      PEND_FULL
   } pend_state_t;

   // Codes above 9 map to 'P'.
   function automatic logic [SEG_W-1:0] digit_code(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_P;
      endcase
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the last count of each slot.
module scan_prescaler #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = $clog2(SCAN_DIV);

   logic [CW-1:0] count;

   assign tick = (count == CW'(SCAN_DIV - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seg_frame_scanner.sv
// Multiplexed eight-digit display scanner with a one-deep frame buffer, per-digit
// blinking and registered active-low anode/cathode drive with one dead cycle per slot.
module seg_frame_scanner
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 100000,
   parameter int unsigned BLINK_SCANS = 250
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_valid,
   output logic                        frame_ready,
   input  logic [NUM_DIGITS-1:0]       an_en,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
   input  logic [NUM_DIGITS-1:0]       blink_mask,
   output logic [NUM_DIGITS-1:0]       AN_Out,
   output logic [SEG_W-1:0]            C_Out,
   output logic                        scan_wrap
);

   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam int unsigned BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   logic          tick;
   logic          wrap_tick;
   logic          accept;
   logic          load;
   logic          digit_on;
   logic [IW-1:0] idx;
   logic [BW-1:0] scan_cnt;
   logic          phase;
   frame_t        pending;
   frame_t        active;
   pend_state_t   pend_state;
   pend_state_t   pend_next;

   scan_prescaler #(
      .SCAN_DIV(SCAN_DIV)
   ) u_prescaler (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   assign wrap_tick = tick && (idx == IW'(NUM_DIGITS - 1));

   // Pending-buffer occupancy: state register, next state, outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_state <= PEND_EMPTY;
      end else begin
         pend_state <= pend_next;
      end
   end

   always_comb begin
      pend_next = pend_state;
      case (pend_state)
         PEND_EMPTY: if (frame_valid) pend_next = PEND_FULL;
         PEND_FULL:  if (wrap_tick)   pend_next = PEND_EMPTY;
         default:    pend_next = PEND_EMPTY;
      endcase
   end

   always_comb begin
      frame_ready = (pend_state == PEND_EMPTY);
      accept      = frame_valid && frame_ready;
      load        = wrap_tick && (pend_state == PEND_FULL);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pending   <= '0;
         active    <= '0;
         idx       <= '0;
         scan_cnt  <= '0;
         phase     <= 1'b0;
         scan_wrap <= 1'b0;
      end else begin
         scan_wrap <= wrap_tick;
         if (accept) pending <= {an_en, seg_data, blink_mask};
         if (load)   active  <= pending;
         if (tick)   idx     <= idx + 1'b1;
         if (wrap_tick) begin
            if (scan_cnt == BW'(BLINK_SCANS - 1)) begin
               scan_cnt <= '0;
               phase    <= ~phase;
            end else begin
               scan_cnt <= scan_cnt + 1'b1;
            end
         end
      end
   end

   assign digit_on = active.en[idx] && !(phase && active.blink[idx]);

   // A tick forces the blank dead cycle while idx steps to the next digit.
   always_ff @(posedge clk) begin
      if (!reset || tick || !digit_on) begin
         AN_Out <= BLANK_AN;
         C_Out  <= BLANK_SEG;
      end else begin
         AN_Out <= ~(NUM_DIGITS'(1) << idx);
         C_Out  <= ~active.seg[idx];
      end
   end

endmodule

// File: tb/tb_seg_frame_scanner.sv
// Self-checking bench: a cycle-indexed reference model derives slot, digit, scan and
// blink phase arithmetically from the cycle count since reset release.
module tb_seg_frame_scanner;
   import seg_pkg::*;

   localparam int unsigned DIV  = 4;
   localparam int unsigned BS   = 2;
   localparam int unsigned SCAN = 8 * DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_valid = 1'b0;
   logic        frame_ready;
   logic [7:0]  an_en = '0;
   logic [55:0] seg_data = '0;
   logic [7:0]  blink_mask = '0;
   logic [7:0]  AN_Out;
   logic [6:0]  C_Out;
   logic        scan_wrap;

   always #5 clk = ~clk;

   seg_frame_scanner #(
      .SCAN_DIV   (DIV),
      .BLINK_SCANS(BS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_valid(frame_valid),
      .frame_ready(frame_ready),
      .an_en      (an_en),
      .seg_data   (seg_data),
      .blink_mask (blink_mask),
      .AN_Out     (AN_Out),
      .C_Out      (C_Out),
      .scan_wrap  (scan_wrap)
   );

   int          compared = 0;
   int          mismatched = 0;
   int unsigned n = 0;
   int unsigned accepted = 0;

   // Model state: displayed frame and pending frame.
   logic [7:0]  a_en, a_blink, p_en, p_blink;
   logic [55:0] a_seg, p_seg;
   bit          p_full;

   function automatic logic [7:0] exp_an();
      int unsigned d, k;
      logic [7:0]  one;
      bit          ph;
      d   = (n / DIV) % 8;
      k   = n / SCAN;
      ph  = ((k / BS) % 2) == 1;
      one = 8'd1;
      if ((n % DIV) == 0 || !a_en[d] || (ph && a_blink[d])) return 8'hFF;
      return ~(one << d);
   endfunction

   function automatic logic [6:0] exp_c();
      int unsigned d;
      d = (n / DIV) % 8;
      if (exp_an() == 8'hFF) return 7'h7F;
      return ~a_seg[7*d +: 7];
   endfunction

   function automatic logic exp_ready();
      return !p_full;
   endfunction

   function automatic logic exp_wrap();
      return (n > 0) && ((n % SCAN) == 0);
   endfunction

   task automatic step();
      @(posedge clk);
      if (p_full && (n % SCAN) == SCAN - 1) begin
         a_en = p_en; a_seg = p_seg; a_blink = p_blink;
         p_full = 1'b0;
      end else if (frame_valid && !p_full) begin
         p_en = an_en; p_seg = seg_data; p_blink = blink_mask;
         p_full = 1'b1;
         accepted++;
      end
      n++;
      @(negedge clk);
   endtask

   // Leaves reset low at a falling edge with the model cleared; caller releases it.
   task automatic hold_reset(input int unsigned cycles);
      reset = 1'b0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      a_en = '0; a_seg = '0; a_blink = '0;
      p_en = '0; p_seg = '0; p_blink = '0;
      p_full = 1'b0;
      n = 0;
   endtask

   task automatic random_frame();
      an_en          = 8'($urandom());
      blink_mask     = 8'($urandom());
      seg_data[31:0]  = $urandom();
      seg_data[55:32] = 24'($urandom());
   endtask

   task automatic test_reset();
      frame_valid = 1'b1;
      random_frame();
      hold_reset(3);
      compared++;
      if (AN_Out !== 8'hFF || C_Out !== 7'h7F || frame_ready !== 1'b1 || scan_wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_values: got AN=%h C=%h rdy=%b wrap=%b, want AN=ff C=7f rdy=1 wrap=0",
                  AN_Out, C_Out, frame_ready, scan_wrap);
      end
      frame_valid = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 100; i++) begin
         compared++;
         if (AN_Out !== 8'hFF || C_Out !== 7'h7F || frame_ready !== 1'b1 || scan_wrap !== exp_wrap()) begin
            mismatched++;
            $display("FAIL idle_blank n=%0d: got AN=%h C=%h rdy=%b wrap=%b, want AN=ff C=7f rdy=1 wrap=%b",
                     n, AN_Out, C_Out, frame_ready, scan_wrap, exp_wrap());
         end
         step();
      end
   endtask

   task automatic test_digits();
      logic [7:0] e_an;
      logic [6:0] e_c;
      int unsigned d;
      an_en = 8'h81; blink_mask = 8'h00; seg_data = '0;
      seg_data[55:49] = SEG_0;
      seg_data[6:0]   = SEG_3;
      frame_valid = 1'b1;
      for (int i = 0; i < 4 * SCAN; i++) begin
         e_an = exp_an(); e_c = exp_c();
         compared++;
         if (AN_Out !== e_an || C_Out !== e_c || frame_ready !== exp_ready() || scan_wrap !== exp_wrap()) begin
            mismatched++;
            $display("FAIL digits n=%0d: got AN=%h C=%b rdy=%b wrap=%b, want AN=%h C=%b rdy=%b wrap=%b",
                     n, AN_Out, C_Out, frame_ready, scan_wrap, e_an, e_c, exp_ready(), exp_wrap());
         end
         if (a_en == 8'h81 && (n % DIV) != 0) begin
            d = (n / DIV) % 8;
            e_an = (d == 0) ? 8'hFE : (d == 7) ? 8'h7F : 8'hFF;
            e_c  = (d == 0) ? 7'b0110000 : (d == 7) ? 7'b1000000 : 7'h7F;
            compared++;
            if (AN_Out !== e_an || C_Out !== e_c) begin
               mismatched++;
               $display("FAIL digits_fixed n=%0d: got AN=%h C=%b, want AN=%h C=%b", n, AN_Out, C_Out, e_an, e_c);
            end
         end
         step();
         frame_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  f_en [3];
      logic [55:0] f_seg [3];
      int unsigned sent, acc0;
      bit          hs;
      hold_reset(1);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         f_en[i] = 8'($urandom()) | 8'h01;
         f_seg[i][31:0]  = $urandom();
         f_seg[i][55:32] = 24'($urandom());
      end
      sent = 0; acc0 = accepted;
      blink_mask = '0; an_en = f_en[0]; seg_data = f_seg[0]; frame_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         compared++;
         if (AN_Out !== exp_an() || C_Out !== exp_c() || frame_ready !== exp_ready() || scan_wrap !== exp_wrap()) begin
            mismatched++;
            $display("FAIL back_to_back n=%0d: got AN=%h C=%b rdy=%b wrap=%b, want AN=%h C=%b rdy=%b wrap=%b",
                     n, AN_Out, C_Out, frame_ready, scan_wrap, exp_an(), exp_c(), exp_ready(), exp_wrap());
         end
         hs = frame_valid && frame_ready;
         step();
         if (hs) begin
            sent++;
            if (sent < 3) begin
               an_en = f_en[sent]; seg_data = f_seg[sent];
            end else begin
               frame_valid = 1'b0;
            end
         end
      end
      compared++;
      if (sent !== 3 || (accepted - acc0) !== 3) begin
         mismatched++;
         $display("FAIL b2b_count: got sent=%0d accepted=%0d, want 3 and 3", sent, accepted - acc0);
      end
   endtask

   task automatic test_wrap_offer();
      logic [7:0] e_an;
      hold_reset(1);
      reset = 1'b1;
      an_en = 8'h01; blink_mask = '0; seg_data = '0; seg_data[6:0] = SEG_7;
      for (int i = 0; i < 3 * SCAN; i++) begin
         frame_valid = (n == SCAN - 1);
         compared++;
         if (AN_Out !== exp_an() || C_Out !== exp_c() || frame_ready !== exp_ready() || scan_wrap !== exp_wrap()) begin
            mismatched++;
            $display("FAIL wrap_offer n=%0d: got AN=%h C=%b rdy=%b wrap=%b, want AN=%h C=%b rdy=%b wrap=%b",
                     n, AN_Out, C_Out, frame_ready, scan_wrap, exp_an(), exp_c(), exp_ready(), exp_wrap());
         end
         if ((n % SCAN) == 1 && n > SCAN) begin
            e_an = (n < 2 * SCAN) ? 8'hFF : 8'hFE;
            compared++;
            if (AN_Out !== e_an) begin
               mismatched++;
               $display("FAIL wrap_offer_slot0 n=%0d: got AN=%h, want AN=%h", n, AN_Out, e_an);
            end
         end
         step();
      end
      frame_valid = 1'b0;
   endtask

   task automatic test_blink();
      int unsigned lit, want;
      hold_reset(1);
      reset = 1'b1;
      an_en = 8'h01; blink_mask = 8'h01; seg_data = '0; seg_data[6:0] = SEG_8;
      frame_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         lit = 0;
         for (int i = 0; i < SCAN; i++) begin
            compared++;
            if (AN_Out !== exp_an() || C_Out !== exp_c() || frame_ready !== exp_ready() || scan_wrap !== exp_wrap()) begin
               mismatched++;
               $display("FAIL blink n=%0d: got AN=%h C=%b rdy=%b wrap=%b, want AN=%h C=%b rdy=%b wrap=%b",
                        n, AN_Out, C_Out, frame_ready, scan_wrap, exp_an(), exp_c(), exp_ready(), exp_wrap());
            end
            if (AN_Out == 8'hFE) lit++;
            step();
            frame_valid = 1'b0;
         end
         want = (k >= 1 && ((k / BS) % 2) == 0) ? DIV - 1 : 0;
         compared++;
         if (lit !== want) begin
            mismatched++;
            $display("FAIL blink_scan k=%0d: got lit=%0d, want lit=%0d", k, lit, want);
         end
      end
   endtask

   task automatic test_reset_pending();
      hold_reset(1);
      reset = 1'b1;
      an_en = 8'hFF; blink_mask = '0;
      for (int i = 0; i < 8; i++) seg_data[7*i +: 7] = SEG_8;
      frame_valid = 1'b1;
      step();
      frame_valid = 1'b0;
      while (n < SCAN + 10) step();
      random_frame();
      an_en = 8'hFF;
      frame_valid = 1'b1;
      step();
      compared++;
      if (frame_ready !== 1'b0 || AN_Out === 8'hFF) begin
         mismatched++;
         $display("FAIL pending_setup: got rdy=%b AN=%h, want rdy=0 and a lit digit", frame_ready, AN_Out);
      end
      hold_reset(1);
      compared++;
      if (AN_Out !== 8'hFF || C_Out !== 7'h7F || frame_ready !== 1'b1 || scan_wrap !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_reset: got AN=%h C=%h rdy=%b wrap=%b, want AN=ff C=7f rdy=1 wrap=0",
                  AN_Out, C_Out, frame_ready, scan_wrap);
      end
      frame_valid = 1'b0;
      reset = 1'b1;
      for (int i = 0; i < 3 * SCAN; i++) begin
         compared++;
         if (AN_Out !== 8'hFF || C_Out !== 7'h7F || frame_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL post_reset n=%0d: got AN=%h C=%h rdy=%b, want AN=ff C=7f rdy=1", n, AN_Out, C_Out, frame_ready);
         end
         step();
      end
   endtask

   task automatic test_random();
      bit hs;
      hold_reset(1);
      reset = 1'b1;
      frame_valid = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         compared++;
         if (AN_Out !== exp_an() || C_Out !== exp_c() || frame_ready !== exp_ready() || scan_wrap !== exp_wrap()) begin
            mismatched++;
            $display("FAIL random n=%0d: got AN=%h C=%b rdy=%b wrap=%b, want AN=%h C=%b rdy=%b wrap=%b",
                     n, AN_Out, C_Out, frame_ready, scan_wrap, exp_an(), exp_c(), exp_ready(), exp_wrap());
         end
         compared++;
         if ($countones(~AN_Out) > 1) begin
            mismatched++;
            $display("FAIL onehot n=%0d: got AN=%h, want at most one low bit", n, AN_Out);
         end
         hs = frame_valid && frame_ready;
         step();
         if (hs) frame_valid = 1'b0;
         if (!frame_valid && $urandom_range(3) == 0) begin
            random_frame();
            frame_valid = 1'b1;
         end
      end
      frame_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_digits();
      test_back_to_back();
      test_wrap_offer();
      test_blink();
      test_reset_pending();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seg_frame_scanner.md
SEG_FRAME_SCANNER -- requirements
Module: seg_frame_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 4.
REQ-002 Parameter BLINK_SCANS, default 250, number of complete 8-digit scans per blink half-period; legal range >= 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; asserted when low and sampled only on rising clk.
REQ-005 frame_valid  input  1  producer offers a display frame.
REQ-006 frame_ready  output  1  scanner can accept a frame into its pending buffer.
REQ-007 an_en  input  8  per-digit enable; bit i selects digit i; bit 7 is the leftmost digit.
REQ-008 seg_data  input  56  digit i segments in bits [7i+6:7i], ordered {g,f,e,d,c,b,a}, active-high.
REQ-009 blink_mask  input  8  per-digit blink enable, captured with the frame.
REQ-010 AN_Out  output  8  active-low anode drive.
REQ-011 C_Out  output  7  active-low cathodes {g,f,e,d,c,b,a}.
REQ-012 scan_wrap  output  1  one-clk pulse when the digit index wraps from 7 to 0.

Function
REQ-013 Prescaler counts 0..SCAN_DIV-1 and wraps to 0; internal tick is high in the cycle when count == SCAN_DIV-1.
REQ-014 The 3-bit digit index advances on tick and wraps 7 -> 0; scan_wrap pulses in the cycle the index becomes 0.
REQ-015 Handshake: a frame transfers only in a cycle with frame_valid && frame_ready; an_en, seg_data and blink_mask are all latched into the pending buffer in that cycle.
REQ-016 frame_ready is low from the cycle after an accepted frame until the cycle after that pending frame moves to active.
REQ-017 Pending moves to active only on a tick that wraps the index 7 -> 0; displayed content never changes mid-scan.
REQ-018 A frame accepted in the wrap cycle itself waits until the following wrap.
REQ-019 frame_valid with frame_ready low is ignored; the producer holds data until the handshake completes.
REQ-020 Dead time: in the cycle after each tick, AN_Out = 8'hFF and C_Out = 7'h7F.
REQ-021 From the second cycle after a tick, until the next tick, AN_Out has bit idx low and all other bits high, and C_Out = ~active_seg[idx].
REQ-022 A digit outputs AN_Out = 8'hFF and C_Out = 7'h7F during its slot when active_en[idx] = 0.
REQ-023 A digit also outputs AN_Out = 8'hFF and C_Out = 7'h7F when blink phase = 1 and active_blink[idx] = 1.
REQ-024 Blink phase toggles after every BLINK_SCANS wraps; the scan counter wraps BLINK_SCANS-1 -> 0.
REQ-025 At most one AN_Out bit is low in any cycle.
REQ-026 AN_Out and C_Out are driven directly from flops, with no combinational path from any input.

Reset
REQ-027 While reset is low at a rising edge: prescaler = 0, index = 0, blink phase = 0, blink scan counter = 0.
REQ-028 While reset is low at a rising edge: active and pending buffers are cleared (en = 0), and the pending buffer is marked empty.
REQ-029 Reset output values: AN_Out = 8'hFF, C_Out = 7'h7F, frame_ready = 1, scan_wrap = 0.
REQ-030 Handshakes in reset cycles are discarded.
REQ-031 Reset asserted mid-scan or with a pending frame discards that frame, and the display is blank on the next edge.

Structure
REQ-032 Shared package seg_pkg holds NUM_DIGITS = 8, SEG_W = 7, the digit encodings 0-9 plus 'P' (7'b1110011), and BLANK_AN / BLANK_SEG constants.
REQ-033 The prescaler is a sub-module, scan_prescaler (parameter SCAN_DIV; ports clk, reset, tick).
REQ-034 All other logic (buffers, index, blink, output registers) resides in seg_frame_scanner.

Verification (SCAN_DIV=4, BLINK_SCANS=2)
REQ-035 Reset then no frame -> AN_Out = FF and C_Out = 7F for 100 cycles; frame_ready = 1.
REQ-036 Frame an_en = 8'h81, seg_data = digit7 '0' (0111111), digit0 '3' (1001111), others 0 -> after the next wrap: digit0 slot AN_Out = FE, C_Out = 7'b0110000; digit7 slot AN_Out = 7F, C_Out = 7'b1000000; slots 1-6 blank; every slot starts with one FF/7F cycle.
REQ-037 Hold frame_valid high across two frames -> second accepted only after the first reaches active; frame_ready low exactly over the pending interval; no frame lost or duplicated.
REQ-038 Frame offered in the wrap cycle -> displayed starting at the following wrap, not the current one.
REQ-039 blink_mask = 8'h01, digit0 enabled -> digit0 shown for 2 scans, blank for 2 scans, repeating; other digits unaffected.
REQ-040 Reset low for one cycle mid-slot with a pending frame -> next edge outputs FF/7F, frame_ready = 1, pending frame never displayed.
